// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the MEM/WB pipeline stage.
package cpu_types_pkg;

  // Deepest MEM/WB pipeline the stage can be built with.
  localparam int MEMWB_MAX_STAGES = 4;

  // MEM/WB payload at the default 32-bit data / 5-bit register-select sizing.
  typedef struct packed {
    logic [31:0] dload;
    logic [31:0] alu;
    logic        reg_wr;
    logic [4:0]  wsel;
    logic        write_sig;
    logic        halt;
  } memwb_payload_t;

  localparam int MEMWB_PAYLOAD_W = $bits(memwb_payload_t);

endpackage

// File: rtl/mem_wb_slot.sv
// One valid-tagged payload register of the MEM/WB pipeline.
// Clear wins over load; a cleared slot is a bubble with an all-zero payload.
module mem_wb_slot #(
  parameter int PW = 72
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load_i,
  input  logic          clr_i,
  input  logic [PW-1:0] d_i,
  output logic          vld_o,
  output logic [PW-1:0] q_o
);

  logic          vld_q, vld_d;
  logic [PW-1:0] pay_q, pay_d;

  // Next-state selection: clear, load or hold.
  always_comb begin
    vld_d = vld_q;
    pay_d = pay_q;
    if (clr_i) begin
      vld_d = 1'b0;
      pay_d = '0;
    end else if (load_i) begin
      vld_d = 1'b1;
      pay_d = d_i;
    end
  end

  // Slot register; reset empties the slot and zeroes its payload.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= 1'b0;
      pay_q <= '0;
    end else begin
      vld_q <= vld_d;
      pay_q <= pay_d;
    end
  end

  assign vld_o = vld_q;
  assign q_o   = pay_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: STAGES valid-tagged slots with ready/valid on both
// sides, flush, sticky halt, writeback-data mux and retired counter.
module mem_wb_pipe
  import cpu_types_pkg::*;
#(
  parameter int DW     = 32,
  parameter int RW     = 5,
  parameter int STAGES = 1,
  parameter int CW     = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW-1:0]                 dload_i,
  input  logic [DW-1:0]                 alu_i,
  input  logic                          reg_wr_i,
  input  logic [RW-1:0]                 wsel_i,
  input  logic                          write_sig_i,
  input  logic                          halt_i,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DW-1:0]                 dload_o,
  output logic [DW-1:0]                 alu_o,
  output logic                          reg_wr_o,
  output logic [RW-1:0]                 wsel_o,
  output logic                          write_sig_o,
  output logic [DW-1:0]                 wdat_o,
  output logic                          halt_o,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  output logic [CW-1:0]                 retired
);

  // Payload layout, LSB first: halt, write_sig, wsel, reg_wr, alu, dload.
  localparam int PW     = 2*DW + RW + 3;
  localparam int OW     = $clog2(STAGES+1);
  localparam int WS_B   = 1;
  localparam int SEL_LO = 2;
  localparam int RWR_B  = RW + 2;
  localparam int ALU_LO = RW + 3;
  localparam int DL_LO  = RW + 3 + DW;

  if (STAGES < 1 || STAGES > MEMWB_MAX_STAGES) begin : g_bad_stages
    $error("mem_wb_pipe: STAGES must be 1..%0d", MEMWB_MAX_STAGES);
  end

  logic [PW-1:0]     in_pay;
  logic [PW-1:0]     head_pay;
  logic [STAGES-1:0] vld_vec;
  logic              accept;
  logic              head_hs;
  logic              halt_q, halt_d;
  logic [CW-1:0]     retired_q, retired_d;
  logic [OW-1:0]     occ_cnt;

  assign in_pay = {dload_i, alu_i, reg_wr_i, wsel_i, write_sig_i, halt_i};

  // Slot chain: slot i moves into slot i+1 when i+1 is empty or moving on.
  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic          vld;
    logic          adv;
    logic          load;
    logic          clr;
    logic [PW-1:0] d;
    logic [PW-1:0] pay;

    if (i == STAGES-1) begin : g_head
      assign adv = vld & out_ready;
    end else begin : g_body
      assign adv = vld & (~g_slot[i+1].vld | g_slot[i+1].adv);
    end

    if (i == 0) begin : g_first
      assign load = accept;
      assign clr  = flush | (adv & ~accept);
      assign d    = in_pay;
    end else begin : g_next
      assign load = g_slot[i-1].adv;
      assign clr  = flush | (adv & ~g_slot[i-1].adv);
      assign d    = g_slot[i-1].pay;
    end

    mem_wb_slot #(.PW(PW)) u_slot (
      .CLK    (CLK),
      .RST    (RST),
      .load_i (load),
      .clr_i  (clr),
      .d_i    (d),
      .vld_o  (vld),
      .q_o    (pay)
    );

    assign vld_vec[i] = vld;
  end

  // Input side: no acceptance once halted; ready ripples back from out_ready.
  assign in_ready = ~halt_q & (~g_slot[0].vld | g_slot[0].adv);
  assign accept   = in_valid & in_ready;

  assign head_pay = g_slot[STAGES-1].pay;
  assign head_hs  = g_slot[STAGES-1].vld & out_ready;

  // Halt and retire bookkeeping; both freeze once a halt has retired.
  always_comb begin
    halt_d    = halt_q;
    retired_d = retired_q;
    if (head_hs && !halt_q) begin
      retired_d = retired_q + CW'(1);
      if (head_pay[0]) halt_d = 1'b1;
    end
  end

  // Sticky halt flag and retired-instruction counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      halt_q    <= halt_d;
      retired_q <= retired_d;
    end
  end

  // Occupancy is the number of valid slots.
  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_cnt = occ_cnt + OW'(vld_vec[i]);
    end
  end

  assign out_valid   = g_slot[STAGES-1].vld;
  assign dload_o     = head_pay[DL_LO +: DW];
  assign alu_o       = head_pay[ALU_LO +: DW];
  assign reg_wr_o    = head_pay[RWR_B] & out_valid;
  assign wsel_o      = head_pay[SEL_LO +: RW];
  assign write_sig_o = head_pay[WS_B];
  assign wdat_o      = write_sig_o ? dload_o : alu_o;
  assign halt_o      = halt_q;
  assign occupancy   = occ_cnt;
  assign retired     = retired_q;

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM/WB pipeline stage for the CPU datapath.
- Carries load data, ALU result, register-write control and halt from the memory stage to writeback, through STAGES valid-tagged register slots with a ready/valid handshake on both sides.
- Adds stall back-pressure, flush, sticky halt, a muxed writeback-data output and a retired-instruction counter. The current single-latch interface has none of these.

Parameters:
DW, 32, data width of load data, ALU result and writeback data
RW, 5, register-select width
STAGES, 1, number of pipeline slots (legal 1..4)
CW, 32, retired-counter width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
in_valid  in  1  memory stage presents an instruction
in_ready  out  1  block accepts the instruction this cycle
dload_i  in  DW  data loaded from memory
alu_i  in  DW  ALU result
reg_wr_i  in  1  instruction writes the register file
wsel_i  in  RW  destination register
write_sig_i  in  1  1 = writeback from dload, 0 = from alu
halt_i  in  1  instruction is a halt
flush  in  1  squash all in-flight entries
out_valid  out  1  head slot holds a valid instruction
out_ready  in  1  writeback consumes the head this cycle
dload_o  out  DW  head load data
alu_o  out  DW  head ALU result
reg_wr_o  out  1  reg_wr of head, gated by out_valid
wsel_o  out  RW  head destination register
write_sig_o  out  1  head writeback select
wdat_o  out  DW  write_sig_o ? dload_o : alu_o
halt_o  out  1  sticky halt
occupancy  out  $clog2(STAGES+1)  number of valid slots
retired  out  CW  count of output handshakes

Behaviour:
- Reset (RST high at a CLK edge): all slot valid bits = 0, payloads = 0, halt_o = 0, retired = 0.
  - Resulting outputs: out_valid = 0, reg_wr_o = 0, occupancy = 0, in_ready = 1.
  - Reset overrides flush and all handshakes, including when asserted mid-stream.
- Slots are numbered 0 (input side) to STAGES-1 (head).
  - Slot i advances into slot i+1 when slot i+1 is empty or is itself advancing.
  - The head advances when out_valid & out_ready.
- in_ready = ~halt_o & (slot0 empty | slot0 advancing). It is combinational from out_ready through the chain; no skid buffer.
- Latency: an accepted instruction reaches out_valid after STAGES cycles when not stalled. Throughput is 1 per cycle when out_ready is held high.
- Stall: with out_ready = 0, all slots hold and in_ready drops once every slot is full. Payloads of held slots must not change.
- Payload of each slot: {dload, alu, reg_wr, wsel, write_sig, halt}. A bubble slot carries 0 payload.
- Flush (edge with flush = 1):
  - All valid bits clear; an incoming handshake in that cycle is dropped.
  - A head handshake in the same cycle still completes: it is counted in retired and still sets halt if it carries halt.
  - Flush beats accept.
- halt_o:
  - Set when the head handshakes with halt = 1; stays 1 until RST.
  - While halt_o = 1: in_ready = 0 and retired freezes.
  - Entries still in flight behind the halt drain normally unless flushed.
- retired increments by 1 on each out_valid & out_ready and wraps modulo 2^CW.
- occupancy updates every cycle as (accepts − head handshakes), adjusted by flush.
- reg_wr_o = 0 whenever out_valid = 0. This prevents spurious register-file writes from bubbles.

Decomposition:
- Shared package cpu_types_pkg holds:
  - a memwb_payload_t packed struct {dload, alu, reg_wr, wsel, write_sig, halt}, sized to the default DW/RW;
  - the constant MEMWB_MAX_STAGES = 4.
- One sub-module: mem_wb_slot, a single valid-tagged payload register with load/clear/hold controls. The top generates STAGES instances plus the advance logic, halt and counter.

Test Plan:
- Streaming, STAGES=2: out_ready=1; send 4 instructions with alu_i=0x10..0x13, write_sig=0 -> out_valid from cycle 2; wdat_o sequence 0x10..0x13 on consecutive cycles; retired=4.
- Stall: STAGES=2; fill with 2 entries; out_ready=0 for 5 cycles -> in_ready=0; occupancy=2; payloads unchanged; on release, entries drain in order.
- Writeback mux / bubble gating: entry with dload_i=0xDEADBEEF, alu_i=0x4, write_sig=1, reg_wr=1, wsel=7 -> wdat_o=0xDEADBEEF, wsel_o=7. On the following idle cycle, reg_wr_o=0.
- Flush collision: STAGES=3, pipe full, flush=1, in_valid=1, out_ready=1 in one cycle -> the head retires (retired +1); next cycle occupancy=0 and out_valid=0.
- Halt: send halt entry, then 2 more -> halt_o=1 after the halt handshake; in_ready=0 thereafter; retired stops incrementing; only RST clears halt_o.
- Reset mid-stream: RST asserted with 2 entries in flight -> next cycle all outputs are at reset values and in_ready=1.
